// File: rtl/alu_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// alu_arbiter_ctrl
// Shares one 5-bit ALU between two requesters. A round-robin grant in IDLE
// accepts one operation over valid/ready, the operands and selection are
// registered into the ALU, and after ALU_LAT settle cycles the ALU outputs
// are captured into a held response. The NOT operation leaves ALU result
// bits [9:5] undriven, so they are cleared here and isZero is recomputed.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid0/1, req_ready0/1    request handshake per requester
//   req_A0/B0/sel0, req_A1/B1/sel1 operands and ALU selection per requester
//   alu_A, alu_B, alu_selection   registered ALU inputs
//   alu_Result, alu_Cout, alu_AlessB, alu_AgreaterB, alu_isNeg  ALU outputs
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_Result, rsp_Cout, rsp_AlessB, rsp_AgreaterB,
//   rsp_isNeg, rsp_isZero         captured response
// ---------------------------------------------------------------------------
module alu_arbiter_ctrl #(
    parameter int ALU_LAT = 1  // settle cycles, 1..4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid0,
    input  logic       req_valid1,
    output logic       req_ready0,
    output logic       req_ready1,
    input  logic [4:0] req_A0,
    input  logic [4:0] req_B0,
    input  logic [4:0] req_A1,
    input  logic [4:0] req_B1,
    input  logic [1:0] req_sel0,
    input  logic [1:0] req_sel1,
    output logic [4:0] alu_A,
    output logic [4:0] alu_B,
    output logic [1:0] alu_selection,
    input  logic [9:0] alu_Result,
    input  logic       alu_Cout,
    input  logic       alu_AlessB,
    input  logic       alu_AgreaterB,
    input  logic       alu_isNeg,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [9:0] rsp_Result,
    output logic       rsp_Cout,
    output logic       rsp_AlessB,
    output logic       rsp_AgreaterB,
    output logic       rsp_isNeg,
    output logic       rsp_isZero
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

    state_t     state_q;
    logic       last_q;      // requester granted most recently
    logic       id_q;        // requester of the operation in flight
    logic [1:0] cnt_q;
    logic [4:0] alu_a_q, alu_b_q;
    logic [1:0] alu_sel_q;
    logic       rsp_valid_q, rsp_id_q;
    logic [9:0] rsp_result_q;
    logic       rsp_cout_q, rsp_lt_q, rsp_gt_q, rsp_neg_q, rsp_zero_q;

    logic       grant0_d, grant1_d;
    logic [9:0] result_d;
    logic       cout_d;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (state_q == IDLE && !reset) begin
            // On a tie, the requester not granted last time wins.
            grant0_d = req_valid0 && (!req_valid1 || last_q);
            grant1_d = req_valid1 && (!req_valid0 || !last_q);
        end

        // NOT drives only the low five result bits; the rest is stale.
        result_d = alu_Result;
        cout_d   = alu_Cout;
        if (alu_sel_q == 2'b11) begin
            result_d = {5'b0, alu_Result[4:0]};
            cout_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_d || grant1_d) begin
                        alu_a_q   <= grant1_d ? req_A1   : req_A0;
                        alu_b_q   <= grant1_d ? req_B1   : req_B0;
                        alu_sel_q <= grant1_d ? req_sel1 : req_sel0;
                        id_q      <= grant1_d;
                        last_q    <= grant1_d;
                        cnt_q     <= LAT_M1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= id_q;
                        rsp_result_q <= result_d;
                        rsp_cout_q   <= cout_d;
                        rsp_lt_q     <= alu_AlessB;
                        rsp_gt_q     <= alu_AgreaterB;
                        rsp_neg_q    <= alu_isNeg;
                        rsp_zero_q   <= (result_d == 10'd0);
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready0    = grant0_d;
    assign req_ready1    = grant1_d;
    assign alu_A         = alu_a_q;
    assign alu_B         = alu_b_q;
    assign alu_selection = alu_sel_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_Result    = rsp_result_q;
    assign rsp_Cout      = rsp_cout_q;
    assign rsp_AlessB    = rsp_lt_q;
    assign rsp_AgreaterB = rsp_gt_q;
    assign rsp_isNeg     = rsp_neg_q;
    assign rsp_isZero    = rsp_zero_q;

endmodule
